instr_fetch: RTL and testbench

Instruction fetch unit: the read initiator for the byte-addressed, big-endian instruction ROM. It drives the ROM's active-low read enable and byte address, and captures the 32-bit word returned combinationally in the same cycle. Captured words go into a 2-entry prefetch queue that feeds the decode stage over a valid/ready handshake. The unit also accepts PC redirects from branch/jump logic and stops fetching at the ROM's end.

---
 rtl/instr_fetch.sv | 124 ++++++++++++
 tb/tb_instr_fetch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads a big-endian byte-addressed ROM into a 2-entry prefetch queue.
// Optional build macro FETCH_ALIGN_CHECK_EN halts fetching on a misaligned redirect target.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned ROM_BYTES = 100
) (
   input  logic        clk,
   input  logic        rst,
   output logic        rom_nrd,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   output logic        fault_oor,
   output logic        fault_align
);

   typedef enum logic {RUN, HALT} state_t;

   localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);
`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   state_t      state, state_next;
   logic [31:0] fetch_pc;
   logic [1:0]  count;
   logic [31:0] tail_data, tail_pc;
   logic        pop, fetch, in_range, bad_align, oor_hit;

   assign instr_valid = (count != 2'd0);
   assign pop         = instr_valid & instr_ready;
   assign in_range    = (fetch_pc <= LAST_PC);
   assign bad_align   = ALIGN_CHECK & (redirect_pc[1:0] != 2'b00);
   assign rom_nrd     = ~fetch;
   assign rom_addr    = rst ? RESET_PC : fetch_pc;

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_next;
   end

   // Redirect overrides everything; otherwise an out-of-range RUN cycle halts.
   always_comb begin
      state_next = state;
      fetch      = 1'b0;
      oor_hit    = 1'b0;
      if (redirect_valid) begin
         state_next = bad_align ? HALT : RUN;
      end else if (state == RUN) begin
         if (!in_range) begin
            state_next = HALT;
            oor_hit    = 1'b1;
         end else if ((count != 2'd2) || pop) begin
            fetch = ~rst;
         end
      end
   end

   // The head entry lives directly in instr/instr_pc; tail_* is the second slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc  <= RESET_PC;
         count     <= 2'd0;
         instr     <= 32'h0;
         instr_pc  <= 32'h0;
         tail_data <= 32'h0;
         tail_pc   <= 32'h0;
         fault_oor <= 1'b0;
      end else if (redirect_valid) begin
         count     <= 2'd0;
         fetch_pc  <= {redirect_pc[31:2], 2'b00};
         fault_oor <= 1'b0;
      end else begin
         if (oor_hit) fault_oor <= 1'b1;
         if (fetch) fetch_pc <= fetch_pc + 32'd4;
         case ({fetch, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  instr    <= rom_data;
                  instr_pc <= fetch_pc;
               end else begin
                  tail_data <= rom_data;
                  tail_pc   <= fetch_pc;
               end
               count <= count + 2'd1;
            end
            2'b01: begin
               instr    <= tail_data;
               instr_pc <= tail_pc;
               count    <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  instr    <= rom_data;
                  instr_pc <= fetch_pc;
               end else begin
                  instr     <= tail_data;
                  instr_pc  <= tail_pc;
                  tail_data <= rom_data;
                  tail_pc   <= fetch_pc;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst)                 fault_align <= 1'b0;
      else if (redirect_valid) fault_align <= bad_align;
   end
`else
   assign fault_align = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed plan followed by random traffic against a queue model.
module tb_instr_fetch;

   localparam int ROM_BYTES = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rom_nrd;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        fault_oor;
   logic        fault_align;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem [ROM_BYTES];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   entry_t      mq[$];
   logic [31:0] m_pc;
   logic        m_halted, m_oor, m_align;

   instr_fetch #(.RESET_PC(32'h0), .ROM_BYTES(ROM_BYTES)) dut (
      .clk(clk), .rst(rst), .rom_nrd(rom_nrd), .rom_addr(rom_addr), .rom_data(rom_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
      .fault_oor(fault_oor), .fault_align(fault_align)
   );

   always #5 clk = ~clk;

   // Big-endian word read; bytes past the ROM end read as zero.
   function automatic logic [31:0] romWord(input logic [31:0] a);
      logic [31:0] w = 32'h0;
      for (int i = 0; i < 4; i++) begin
         longint idx = longint'(a) + i;
         w = {w[23:0], (idx < ROM_BYTES) ? mem[int'(idx)] : 8'h00};
      end
      return w;
   endfunction

   assign rom_data = rom_nrd ? 32'h0 : romWord(rom_addr);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic modelFetch(input logic rdy, input logic rv, input logic rs);
      logic pop = (mq.size() > 0) && rdy;
      return !rs && !m_halted && (m_pc <= ROM_BYTES - 4) && (mq.size() < 2 || pop) && !rv;
   endfunction

   task automatic modelReset();
      mq.delete();
      m_pc = 32'h0; m_halted = 1'b0; m_oor = 1'b0; m_align = 1'b0;
   endtask

   // Drive one cycle of inputs, compare all outputs against the model, then advance the model.
   task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rs);
      logic f;
      @(negedge clk);
      instr_ready = rdy; redirect_valid = rv; redirect_pc = rpc; rst = rs;
      #1;
      f = modelFetch(rdy, rv, rs);
      checkOutput("rom_nrd", 32'(rom_nrd), 32'(!f));
      checkOutput("rom_addr", rom_addr, rs ? 32'h0 : m_pc);
      checkOutput("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
         checkOutput("instr", instr, mq[0].data);
         checkOutput("instr_pc", instr_pc, mq[0].pc);
      end
      checkOutput("fault_oor", 32'(fault_oor), 32'(m_oor));
      checkOutput("fault_align", 32'(fault_align), 32'(m_align));
      if (rs) begin
         modelReset();
      end else if (rv) begin
         mq.delete();
         m_pc = {rpc[31:2], 2'b00};
         m_oor = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
         m_align  = (rpc[1:0] != 2'b00);
         m_halted = m_align;
`else
         m_halted = 1'b0;
`endif
      end else begin
         if (mq.size() > 0 && rdy) void'(mq.pop_front());
         if (f) begin
            mq.push_back('{pc: m_pc, data: romWord(m_pc)});
            m_pc = m_pc + 32'd4;
         end else if (!m_halted && m_pc > ROM_BYTES - 4) begin
            m_halted = 1'b1;
            m_oor = 1'b1;
         end
      end
      @(posedge clk);
   endtask

   initial begin
      logic [31:0] rpc;
      for (int i = 0; i < ROM_BYTES; i++) mem[i] = 8'($urandom);
      modelReset();
      @(posedge clk);

      // Reset then streaming with ready held high
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("stream_pc", instr_pc, 32'd16);

      // Backpressure from reset, then release
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("bp_rom_nrd", 32'(rom_nrd), 32'd1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

      // Redirect to 0x40 with a full queue
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h40, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

      // Run to the ROM end, then recover with a redirect to 0
      applyStimulus(1'b1, 1'b1, 32'h0, 1'b0);
      for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("oor_sticky", 32'(fault_oor), 32'd1);
      applyStimulus(1'b1, 1'b1, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

      // Misaligned redirect
      applyStimulus(1'b1, 1'b1, 32'h22, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

      // Reset with two entries queued
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         rpc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
         applyStimulus(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), rpc,
                       ($urandom_range(0, 199) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
